// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues instruction reads, and drives
// the fetch/decode pipeline register under hazard-unit control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pcen,
  input  logic [1:0]  PCSel,
  input  logic        deen,
  input  logic        deflush,
  input  logic [31:0] jr_target,
  input  logic [25:0] j_addr,
  input  logic [31:0] br_target,
  input  logic        halt,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] de_instr,
  output logic [31:0] de_npc,
  output logic        de_valid,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  state_t      state, next_state;
  logic [31:0] pc, pc_plus4, next_pc, hold_buf, cur_instr;
  logic        pc_load, buf_load, de_load, de_clr;
  logic        unused;

  assign unused   = ^{jr_target[1:0], br_target[1:0]};
  assign pc_plus4 = pc + 32'd4;
  assign iaddr    = pc;
  assign halted   = (state == HALT);

  always_comb begin
    next_pc = pc_plus4;
    case (PCSel)
      2'd0: next_pc = pc_plus4;
      2'd1: next_pc = {jr_target[31:2], 2'b00};
      2'd2: next_pc = {de_npc[31:28], j_addr, 2'b00};
      2'd3: next_pc = {br_target[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    ihit       = 1'b0;
    cur_instr  = iload;
    pc_load    = 1'b0;
    buf_load   = 1'b0;
    de_load    = 1'b0;
    de_clr     = 1'b0;
    case (state)
      FETCH: begin
        iREN = 1'b1;
        ihit = ~iwait;
        if (ihit) begin
          if (pcen) begin
            pc_load = 1'b1;
          end else begin
            buf_load   = 1'b1;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        ihit      = 1'b1;
        cur_instr = hold_buf;
        if (pcen) begin
          pc_load    = 1'b1;
          next_state = FETCH;
        end
      end
      default: ;
    endcase
    if (state != HALT) begin
      de_clr  = deflush;
      de_load = ~deflush & deen & ihit;
    end
    // halt overrides every update decided above, including the PC and decode register
    if (halt) begin
      next_state = HALT;
      pc_load    = 1'b0;
      buf_load   = 1'b0;
      de_load    = 1'b0;
      de_clr     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      hold_buf <= '0;
      de_instr <= '0;
      de_npc   <= '0;
      de_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (pc_load)  pc       <= next_pc;
      if (buf_load) hold_buf <= iload;
      if (de_clr) begin
        de_instr <= '0;
        de_valid <= 1'b0;
      end else if (de_load) begin
        de_instr <= cur_instr;
        de_npc   <= pc_plus4;
        de_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline: owns the program counter, issues instruction reads to the instruction memory port, and produces the `ihit` strobe consumed by the hazard unit. It applies the hazard unit's `pcen`/`PCSel` controls to select the next PC and its `deen`/`deflush` controls to load or flush the fetch/decode pipeline register. A one-entry hold buffer keeps a returned instruction while the pipeline is stalled, so the same address is not fetched again.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC value after reset.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `pcen`  in  1  PC update enable from hazard unit.
- `PCSel`  in  2  next-PC select: 0 PC+4, 1 jr, 2 jump, 3 branch.
- `deen`  in  1  fetch/decode register load enable.
- `deflush`  in  1  fetch/decode register flush; has priority over `deen`.
- `jr_target`  in  32  register-sourced jr target.
- `j_addr`  in  26  jump index field of the instruction in decode.
- `br_target`  in  32  resolved branch target.
- `halt`  in  1  halt instruction retired.
- `iwait`  in  1  instruction memory busy.
- `iload`  in  32  instruction memory read data.
- `iREN`  out  1  instruction read request.
- `iaddr`  out  32  instruction address (= PC).
- `ihit`  out  1  valid instruction available this cycle.
- `de_instr`  out  32  latched instruction for decode.
- `de_npc`  out  32  PC+4 of `de_instr`.
- `de_valid`  out  1  `de_instr` is a real instruction, not a bubble.
- `halted`  out  1  fetch permanently stopped.

## Operation
- States: FETCH, HOLD, HALT.
- **FETCH**
  - `iREN`=1, `iaddr`=PC.
  - `ihit`=~`iwait`. The current instruction is `iload`.
  - If `ihit` & `pcen`: PC ← next PC; stay in FETCH.
  - If `ihit` & ~`pcen`: buffer ← `iload`; go to HOLD.
- **HOLD**
  - `iREN`=0, `ihit`=1. The current instruction is the buffer.
  - If `pcen`: PC ← next PC; go to FETCH.
- **HALT**
  - `iREN`=0, `ihit`=0, `halted`=1. PC and fetch/decode register are frozen.
  - Left only by `RST`.
- `halt`=1 in any state → HALT next cycle. It has priority over all other updates in that cycle.
- Next PC by `PCSel`:
  - 0: PC+4.
  - 1: {`jr_target`[31:2], 2'b00}.
  - 2: {`de_npc`[31:28], `j_addr`, 2'b00}.
  - 3: {`br_target`[31:2], 2'b00}.
  - All additions are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Fetch/decode register:
  - `deflush`=1: `de_instr` ← 0 (nop), `de_valid` ← 0; `de_npc` unchanged.
  - Else `deen`=1 with `ihit`=1: `de_instr` ← current instruction, `de_npc` ← PC+4, `de_valid` ← 1.
  - Else: hold.
- Redirect out of HOLD (`pcen` with `PCSel`≠0) discards the buffer. The next fetch is the new target.
- The block does no hazard detection of its own and obeys the control inputs exactly.

## Timing
- Reset values: PC=`RESET_PC`, state FETCH, `de_instr`=0, `de_npc`=0, `de_valid`=0, `halted`=0, buffer=0.
- Combinational outputs, unregistered:
  - `iREN`, `iaddr`, `ihit` are functions of state, PC and `iwait` only.
  - `iaddr` is valid in the same cycle the state enters FETCH.
- Throughput: one instruction per cycle while `iwait`=0 and `pcen`=1.
- Fetch latency: an instruction accepted in cycle N appears on `de_instr` in cycle N+1 when `deen`=1.
- Variable `iwait`: `ihit` stays low and PC holds for any number of wait cycles. `iaddr` stays stable throughout.
- Reset mid-operation (`RST`=1 in any state, including HALT or with `iwait`=1): all reset values take effect at the next edge. `iREN` is reasserted from `RESET_PC` in the following cycle.
- Simultaneous `deflush` & `deen`: flush wins.
- Simultaneous `halt` & `pcen`: halt wins; PC is not updated.

## Test plan
- Reset, `iwait`=0, `pcen`=`deen`=1, `PCSel`=0 for 4 cycles -> `iaddr` 0,4,8,12. `de_npc` 4,8,12 one cycle later. `de_valid`=1 from cycle 1.
- `iwait`=1 for 3 cycles at PC=8 -> `ihit`=0 and `iaddr`=8 held for 3 cycles. PC advances to 12 on the cycle `iwait` drops.
- `ihit` with `pcen`=0 for 2 cycles, `iload`=32'h8C22_0004 -> HOLD, `iREN`=0, `ihit`=1. After `pcen` returns, `de_instr`=32'h8C22_0004 and `iaddr`=PC+4.
- `PCSel`=2, `j_addr`=26'h000_0040, `de_npc`=32'h1000_0010 -> next `iaddr`=32'h1000_0100. With `deflush`=1 the same cycle, `de_instr`=0 and `de_valid`=0.
- `PCSel`=1, `jr_target`=32'h0000_0203 -> `iaddr`=32'h0000_0200. `PCSel`=3 at PC=32'hFFFF_FFFC with `br_target`=32'h40 -> 32'h40. `PCSel`=0 at 32'hFFFF_FFFC -> 0.
- `halt`=1 with `pcen`=1 -> `halted`=1, `iREN`=0 and PC frozen indefinitely. `RST`=1 -> `iaddr`=`RESET_PC`, `halted`=0 one cycle later.
